// File: rtl/conv_pkg.sv
// Shared types and constants for the 3-tap convolution engine.
// Imported by conv_engine and conv_mac.
package conv_pkg;

    typedef enum logic [1:0] {
        S_LOAD,
        S_CALC,
        S_DONE,
        S_HOLD
    } state_e;

    localparam int NUM_IN  = 10;
    localparam int NUM_OUT = 8;
    localparam int TAPS    = 3;
    localparam int ACC_W   = 14;

    // Clamp an accumulator value to the 8-bit result range.
    function automatic logic [7:0] sat8(input logic [ACC_W-1:0] v);
        return (|v[ACC_W-1:8]) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Multiply-accumulate datapath with output shift and saturation.
// One tap per cycle; result_o reflects the sum including this cycle's tap.
module conv_mac
    import conv_pkg::*;
#(
    parameter int unsigned SHIFT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic       first_i,
    input  logic [7:0] sample_i,
    input  logic [3:0] weight_i,
    output logic [7:0] result_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] prod;
    logic [ACC_W-1:0] shifted;

    always_comb begin
        prod     = ACC_W'(sample_i) * ACC_W'(weight_i);
        acc_d    = (first_i ? '0 : acc_q) + prod;
        shifted  = acc_d >> SHIFT;
        result_o = sat8(shifted);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/conv_engine.sv
// Frame-based 3-tap FIR: load 10 samples, compute 8 results one MAC
// per cycle, pulse start_d, then hold results until rearmed.
module conv_engine
    import conv_pkg::*;
#(
    parameter logic [3:0]  K0    = 4'd1,
    parameter logic [3:0]  K1    = 4'd2,
    parameter logic [3:0]  K2    = 4'd1,
    parameter int unsigned SHIFT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    output logic       sample_ready,
    input  logic       rearm,
    output logic [7:0] num_A,
    output logic [7:0] num_B,
    output logic [7:0] num_C,
    output logic [7:0] num_D,
    output logic [7:0] num_E,
    output logic [7:0] num_F,
    output logic [7:0] num_G,
    output logic [7:0] num_H,
    output logic       start_d,
    output logic       busy
);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] o_q, o_d;
    logic [1:0] t_q, t_d;

    logic [7:0] buf_q [NUM_IN];
    logic [7:0] num_q [NUM_OUT];

    logic [3:0] tap_idx;
    logic [3:0] weight;
    logic [7:0] mac_res;
    logic       in_calc;
    logic       last_tap;
    logic       accept;

    assign in_calc  = (state_q == S_CALC);
    assign last_tap = (t_q == 2'(TAPS - 1));
    assign accept   = (state_q == S_LOAD) && sample_valid;
    assign tap_idx  = {1'b0, o_q} + {2'b00, t_q};

    always_comb begin
        weight = K2;
        unique case (1'b1)
            (t_q == 2'd0): weight = K0;
            (t_q == 2'd1): weight = K1;
            default:       weight = K2;
        endcase
    end

    conv_mac #(
        .SHIFT(SHIFT)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .en_i     (in_calc),
        .first_i  (t_q == 2'd0),
        .sample_i (buf_q[tap_idx]),
        .weight_i (weight),
        .result_o (mac_res)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        t_d     = t_q;
        unique case (state_q)
            S_LOAD: begin
                if (sample_valid) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'(NUM_IN - 1)) begin
                        state_d = S_CALC;
                        cnt_d   = '0;
                        o_d     = '0;
                        t_d     = '0;
                    end
                end
            end
            S_CALC: begin
                if (last_tap) begin
                    t_d = '0;
                    if (o_q == 3'(NUM_OUT - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        o_d = o_q + 3'd1;
                    end
                end else begin
                    t_d = t_q + 2'd1;
                end
            end
            S_DONE: state_d = S_HOLD;
            S_HOLD: begin
                if (rearm) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            o_q     <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            t_q     <= t_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_IN; i++) begin
                buf_q[i] <= '0;
            end
        end else if (accept) begin
            buf_q[cnt_q] <= sample_in;
        end
    end

    // A result lands on the edge closing its final tap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                num_q[i] <= '0;
            end
        end else if (in_calc && last_tap) begin
            num_q[o_q] <= mac_res;
        end
    end

    assign sample_ready = (state_q == S_LOAD);
    assign start_d      = (state_q == S_DONE);
    assign busy         = in_calc || (state_q == S_DONE);

    assign num_A = num_q[0];
    assign num_B = num_q[1];
    assign num_C = num_q[2];
    assign num_D = num_q[3];
    assign num_E = num_q[4];
    assign num_F = num_q[5];
    assign num_G = num_q[6];
    assign num_H = num_q[7];

endmodule

// File: doc/conv_engine.md
CONV_ENGINE -- requirements
Module: conv_engine

Interface
REQ-001 Parameter K0, default 1: tap-0 weight, unsigned 4-bit.
REQ-002 Parameter K1, default 2: tap-1 weight, unsigned 4-bit.
REQ-003 Parameter K2, default 1: tap-2 weight, unsigned 4-bit.
REQ-004 Parameter SHIFT, default 2: right-shift applied to each accumulated sum, range 0..4.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 sample_in  input  8  unsigned input sample.
REQ-008 sample_valid  input  1  sample_in is valid this cycle.
REQ-009 sample_ready  output  1  engine accepts a sample this cycle.
REQ-010 rearm  input  1  single-cycle pulse releasing the held results and allowing a new frame.
REQ-011 num_A..num_H  output  8 each  convolution results 0..7, registered.
REQ-012 start_d  output  1  single-cycle pulse marking that num_A..num_H are valid; drives the downstream display controller's start input.
REQ-013 busy  output  1  high in CALC and DONE.

Function
REQ-014 FSM states are LOAD, CALC, DONE and HOLD.
REQ-015 LOAD: sample_ready=1; a sample is accepted on each edge where sample_valid=1; samples go to buf[0..9] in arrival order.
REQ-016 LOAD -> CALC on the edge accepting the 10th sample (buf[9]).
REQ-017 CALC: one MAC per cycle; output index o 0..7 outer, tap t 0..2 inner; acc = (t==0 ? 0 : acc) + buf[o+t]*K[t].
REQ-018 Accumulator is 14-bit unsigned; the maximum 3*255*15 = 11475 cannot overflow.
REQ-019 On the edge ending the t=2 cycle of output o, result o = min(acc_final >> SHIFT, 255) is written to num_A (o=0) .. num_H (o=7).
REQ-020 CALC lasts exactly 24 cycles, then -> DONE.
REQ-021 DONE lasts exactly 1 cycle with start_d=1, then -> HOLD.
REQ-022 Latency: start_d is high in the 25th cycle after the edge accepting the 10th sample.
REQ-023 HOLD: sample_ready=0; num_A..num_H stay stable; HOLD -> LOAD on the edge where rearm=1.
REQ-024 sample_ready=0 in CALC, DONE and HOLD; sample_valid is ignored in those states and no sample is lost-counted.
REQ-025 rearm is ignored in LOAD, CALC and DONE.
REQ-026 num_A..num_H change only in CALC, per REQ-019; each holds its previous-frame value until overwritten.
REQ-027 start_d is low in every state except DONE.

Reset
REQ-028 While reset=0: state=LOAD, sample counter=0, acc=0, buf=0, num_A..num_H=0, start_d=0, busy=0; sample_ready=1 once reset is released.
REQ-029 Reset asserted mid-frame (LOAD or CALC) discards the partial frame; no start_d pulse follows.

Structure
REQ-030 Shared package conv_pkg holds the state encoding and the constants NUM_IN=10, NUM_OUT=8, TAPS=3 and ACC_W=14.
REQ-031 One sub-module, conv_mac, holds the multiply, accumulate, shift and saturate datapath; conv_engine holds the FSM, counters, sample buffer and result registers.

Verification
REQ-032 Defaults; 10 samples all 100 -> start_d pulse; num_A..num_H all 100.
REQ-033 Defaults; ramp 0,10,..,90 -> num_A..num_H = 10,20,30,40,50,60,70,80.
REQ-034 K0=K1=K2=15, SHIFT=0; 10 samples all 255 -> all outputs 255 (saturated from 11475).
REQ-035 10th sample accepted at edge N -> start_d high only in cycle N+25; busy high for 25 cycles.
REQ-036 5 samples, then reset pulse, then 10 samples of 40 -> outputs all 40; exactly one start_d pulse.
REQ-037 In HOLD, sample_valid held high for 50 cycles -> sample_ready=0 and outputs unchanged; rearm pulse -> next cycle sample_ready=1.
